// File: rtl/ps2_key_pkg.sv
// Shared types and scan-code constants for the PS/2 held-key tracker.
package ps2_key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK,
    SKIP
  } kstate_e;

  localparam logic [7:0] PFX_EXT      = 8'hE0;
  localparam logic [7:0] PFX_BRK      = 8'hF0;
  localparam logic [7:0] PFX_PAUSE    = 8'hE1;
  localparam logic [7:0] BAT_OK       = 8'hAA;
  localparam logic [7:0] ACK          = 8'hFA;
  localparam logic [7:0] RESEND       = 8'hFE;
  localparam logic [7:0] ECHO         = 8'hEE;
  localparam logic [7:0] KB_OVR0      = 8'h00;
  localparam logic [7:0] KB_OVR1      = 8'hFF;
  localparam logic [7:0] FAKE_SHIFT_L = 8'h12;
  localparam logic [7:0] FAKE_SHIFT_R = 8'h59;

  localparam int KEY_W = 9;
  localparam logic [KEY_W-1:0] KEY_NONE = 9'h000;

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == FAKE_SHIFT_L) || (b == FAKE_SHIFT_R);
  endfunction

endpackage

// File: rtl/ps2_key_table.sv
// Held-key slot table: parallel match, lowest-free-slot insert, remove, flush, popcount.
module ps2_key_table
  import ps2_key_pkg::*;
#(
  parameter int MAX_KEYS = 4,
  parameter int CNT_W    = $clog2(MAX_KEYS + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ins_i,
  input  logic                      rem_i,
  input  logic                      flush_i,
  input  logic [KEY_W-1:0]          code_i,
  output logic                      hit_o,
  output logic                      full_o,
  output logic [KEY_W*MAX_KEYS-1:0] codes_o,
  output logic [MAX_KEYS-1:0]       valid_o,
  output logic [CNT_W-1:0]          count_o
);

  logic [KEY_W-1:0]    code_q [MAX_KEYS];
  logic [MAX_KEYS-1:0] valid_q;
  logic [MAX_KEYS-1:0] hit_vec;
  logic [MAX_KEYS-1:0] free_oh;
  logic                found;

  always_comb begin
    hit_vec = '0;
    free_oh = '0;
    found   = 1'b0;
    count_o = '0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      hit_vec[i] = valid_q[i] && (code_q[i] == code_i);
      if (!valid_q[i] && !found) begin
        free_oh[i] = 1'b1;
        found      = 1'b1;
      end
      count_o = count_o + CNT_W'(valid_q[i]);
    end
  end

  assign hit_o   = |hit_vec;
  assign full_o  = &valid_q;
  assign valid_o = valid_q;

  for (genvar g = 0; g < MAX_KEYS; g++) begin : g_out
    assign codes_o[KEY_W*g +: KEY_W] = code_q[g];
  end

  // Empty slots read back as zero so held_codes never shows stale codes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < MAX_KEYS; i++) code_q[i] <= KEY_NONE;
    end else if (flush_i) begin
      valid_q <= '0;
      for (int i = 0; i < MAX_KEYS; i++) code_q[i] <= KEY_NONE;
    end else begin
      for (int i = 0; i < MAX_KEYS; i++) begin
        if (ins_i && free_oh[i]) begin
          valid_q[i] <= 1'b1;
          code_q[i]  <= code_i;
        end else if (rem_i && hit_vec[i]) begin
          valid_q[i] <= 1'b0;
          code_q[i]  <= KEY_NONE;
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-byte decoder tracking up to MAX_KEYS held keys.
// Optional macro KEY_TRACKER_REPEAT_EN adds key_repeat and reports typematic repeats.
module ps2_key_tracker
  import ps2_key_pkg::*;
#(
  parameter int MAX_KEYS        = 4,
  parameter int CLOCK_FREQUENCY = 25000000,
  parameter int TIMEOUT_US      = 2000
) (
  input  logic                             Clock,
  input  logic                             reset,
  input  logic [7:0]                       ps2_byte,
  input  logic                             ps2_byte_valid,
  output logic [KEY_W*MAX_KEYS-1:0]        held_codes,
  output logic [MAX_KEYS-1:0]              held_valid,
  output logic [$clog2(MAX_KEYS+1)-1:0]    held_count,
  output logic [KEY_W-1:0]                 newest_code,
  output logic                             key_event,
  output logic [KEY_W-1:0]                 event_code,
  output logic                             event_make,
  output logic                             overflow
`ifdef KEY_TRACKER_REPEAT_EN
  ,
  output logic                             key_repeat
`endif
);

  localparam int     CNT_W  = $clog2(MAX_KEYS + 1);
  localparam longint TMO_L  = (longint'(TIMEOUT_US) * longint'(CLOCK_FREQUENCY)) / 64'd1000000;
  localparam int     TMO_CYC = (TMO_L < 1) ? 1 : int'(TMO_L);
  localparam int     TMO_W  = $clog2(TMO_CYC + 1);

  kstate_e          state_q, state_d, eff_state;
  logic [2:0]       skip_q, skip_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_fire;
  logic             do_make, do_brk, do_flush;
  logic [KEY_W-1:0] code_c;
  logic             tbl_hit, tbl_full, tbl_ins, tbl_rem, tbl_rep;
  logic             key_event_q, key_event_d, event_make_q, event_make_d;
  logic             overflow_q, overflow_d, repeat_q, repeat_d;
  logic [KEY_W-1:0] event_code_q, event_code_d, newest_q, newest_d;

  // A timed-out partial sequence is abandoned before this cycle's byte is decoded.
  assign tmo_fire  = (state_q != IDLE) && (tmo_q == TMO_W'(TMO_CYC));

  always_comb begin
    eff_state = tmo_fire ? IDLE : state_q;
    state_d   = eff_state;
    skip_d    = skip_q;
    do_make   = 1'b0;
    do_brk    = 1'b0;
    do_flush  = 1'b0;
    code_c    = {1'b0, ps2_byte};
    if (ps2_byte_valid) begin
      case (eff_state)
        IDLE: begin
          case (ps2_byte)
            PFX_EXT:                    state_d = EXT;
            PFX_BRK:                    state_d = BRK;
            PFX_PAUSE: begin
              state_d = SKIP;
              skip_d  = 3'd7;
            end
            KB_OVR0, KB_OVR1:           do_flush = 1'b1;
            BAT_OK, ACK, RESEND, ECHO:  ;
            default:                    do_make = 1'b1;
          endcase
        end
        EXT: begin
          code_c = {1'b1, ps2_byte};
          if (ps2_byte == PFX_BRK) state_d = EXT_BRK;
          else begin
            state_d = IDLE;
            do_make = !is_fake_shift(ps2_byte);
          end
        end
        BRK: begin
          state_d = IDLE;
          do_brk  = 1'b1;
        end
        EXT_BRK: begin
          code_c  = {1'b1, ps2_byte};
          state_d = IDLE;
          do_brk  = !is_fake_shift(ps2_byte);
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    if (ps2_byte_valid)                                       tmo_d = '0;
    else if ((state_q != IDLE) && (tmo_q != TMO_W'(TMO_CYC))) tmo_d = tmo_q + TMO_W'(1);
    else                                                      tmo_d = tmo_q;
  end

  assign tbl_ins = do_make && !tbl_hit && !tbl_full;
  assign tbl_rem = do_brk && tbl_hit;
  assign tbl_rep = do_make && tbl_hit;

  always_comb begin
    event_code_d = event_code_q;
    event_make_d = event_make_q;
    newest_d     = newest_q;
    overflow_d   = do_flush || (do_make && !tbl_hit && tbl_full);
    repeat_d     = 1'b0;
    key_event_d  = tbl_ins || tbl_rem;
`ifdef KEY_TRACKER_REPEAT_EN
    repeat_d     = tbl_rep;
    key_event_d  = tbl_ins || tbl_rem || tbl_rep;
    if (tbl_rep) begin
      event_code_d = code_c;
      event_make_d = 1'b1;
    end
`endif
    if (tbl_ins) begin
      event_code_d = code_c;
      event_make_d = 1'b1;
      newest_d     = code_c;
    end
    if (tbl_rem) begin
      event_code_d = code_c;
      event_make_d = 1'b0;
      if (code_c == newest_q) newest_d = KEY_NONE;
    end
    if (do_flush) newest_d = KEY_NONE;
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      skip_q       <= '0;
      tmo_q        <= '0;
      key_event_q  <= 1'b0;
      event_code_q <= KEY_NONE;
      event_make_q <= 1'b0;
      newest_q     <= KEY_NONE;
      overflow_q   <= 1'b0;
      repeat_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      tmo_q        <= tmo_d;
      key_event_q  <= key_event_d;
      event_code_q <= event_code_d;
      event_make_q <= event_make_d;
      newest_q     <= newest_d;
      overflow_q   <= overflow_d;
      repeat_q     <= repeat_d;
    end
  end

  ps2_key_table #(
    .MAX_KEYS (MAX_KEYS),
    .CNT_W    (CNT_W)
  ) u_table (
    .clk     (Clock),
    .rst_n   (reset),
    .ins_i   (tbl_ins),
    .rem_i   (tbl_rem),
    .flush_i (do_flush),
    .code_i  (code_c),
    .hit_o   (tbl_hit),
    .full_o  (tbl_full),
    .codes_o (held_codes),
    .valid_o (held_valid),
    .count_o (held_count)
  );

  assign newest_code = newest_q;
  assign key_event   = key_event_q;
  assign event_code  = event_code_q;
  assign event_make  = event_make_q;
  assign overflow    = overflow_q;
`ifdef KEY_TRACKER_REPEAT_EN
  assign key_repeat  = repeat_q;
`else
  logic unused_repeat;
  assign unused_repeat = repeat_q ^ tbl_rep;
`endif

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Scoreboard bench for ps2_key_tracker: expected events queued as bytes are sent.
module tb_ps2_key_tracker;
  localparam int MK = 4;
  localparam int CF = 1000000;
  localparam int TU = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       pbyte = 8'h00;
  logic             pvld = 1'b0;
  logic [9*MK-1:0]  held_codes;
  logic [MK-1:0]    held_valid;
  logic [2:0]       held_count;
  logic [8:0]       newest_code;
  logic             key_event;
  logic [8:0]       event_code;
  logic             event_make;
  logic             overflow;
`ifdef KEY_TRACKER_REPEAT_EN
  logic             key_repeat;
`endif

  typedef struct packed {
    logic [8:0] code;
    logic       make;
    logic       rep;
  } evt_t;

  evt_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   ovf_cnt = 0;

  ps2_key_tracker #(.MAX_KEYS(MK), .CLOCK_FREQUENCY(CF), .TIMEOUT_US(TU)) dut (
    .Clock          (clk),
    .reset          (rst_n),
    .ps2_byte       (pbyte),
    .ps2_byte_valid (pvld),
    .held_codes     (held_codes),
    .held_valid     (held_valid),
    .held_count     (held_count),
    .newest_code    (newest_code),
    .key_event      (key_event),
    .event_code     (event_code),
    .event_make     (event_make),
    .overflow       (overflow)
`ifdef KEY_TRACKER_REPEAT_EN
    ,
    .key_repeat     (key_repeat)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (overflow) ovf_cnt++;
      if (key_event) begin
        check("evt_expected", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          evt_t e;
          e = sb.pop_front();
          check("evt_code", 32'(event_code), 32'(e.code));
          check("evt_make", 32'(event_make), 32'(e.make));
`ifdef KEY_TRACKER_REPEAT_EN
          check("evt_repeat", 32'(key_repeat), 32'(e.rep));
`endif
        end
      end
    end
  end

  task automatic expect_evt(input logic [8:0] code, input logic make, input logic rep);
    evt_t e;
    e.code = code;
    e.make = make;
    e.rep  = rep;
    sb.push_back(e);
  endtask

  task automatic send(input logic [7:0] by);
    @(posedge clk);
    #1;
    pbyte = by;
    pvld  = 1'b1;
    @(posedge clk);
    #1;
    pvld  = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] slot(input int i);
    return held_codes[9*i +: 9];
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int o0;
    idle(3);
    check("rst_count",  32'(held_count),  32'd0);
    check("rst_valid",  32'(held_valid),  32'd0);
    check("rst_newest", 32'(newest_code), 32'd0);
    check("rst_event",  32'(key_event),   32'd0);
    check("rst_ecode",  32'(event_code),  32'd0);
    check("rst_ovf",    32'(overflow),    32'd0);
    rst_n = 1'b1;
    idle(2);

    // Plain make then break
    expect_evt(9'h029, 1'b1, 1'b0);
    send(8'h29);
    check("t1_count_mk", 32'(held_count), 32'd1);
    check("t1_newest",   32'(newest_code), 32'h029);
    expect_evt(9'h029, 1'b0, 1'b0);
    send(8'hF0); send(8'h29);
    check("t1_count_bk", 32'(held_count), 32'd0);
    check("t1_newest_bk", 32'(newest_code), 32'h000);

    // Extended key alongside a normal one
    expect_evt(9'h01D, 1'b1, 1'b0);
    send(8'h1D);
    expect_evt(9'h175, 1'b1, 1'b0);
    send(8'hE0); send(8'h75);
    check("t2_slot0", 32'(slot(0)), 32'h01D);
    check("t2_slot1", 32'(slot(1)), 32'h175);
    check("t2_newest", 32'(newest_code), 32'h175);
    expect_evt(9'h01D, 1'b0, 1'b0);
    send(8'hF0); send(8'h1D);
    check("t2_valid_bk", 32'(held_valid), 32'h2);
    check("t2_newest_bk", 32'(newest_code), 32'h175);
    expect_evt(9'h175, 1'b0, 1'b0);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t2_clean", 32'(held_count), 32'd0);
    check("t2_newest_clean", 32'(newest_code), 32'h000);

    // Fill table, overflow, slot reuse
    expect_evt(9'h015, 1'b1, 1'b0); send(8'h15);
    expect_evt(9'h01C, 1'b1, 1'b0); send(8'h1C);
    expect_evt(9'h024, 1'b1, 1'b0); send(8'h24);
    expect_evt(9'h02D, 1'b1, 1'b0); send(8'h2D);
    check("t3_full_count", 32'(held_count), 32'd4);
    check("t3_slot3", 32'(slot(3)), 32'h02D);
    o0 = ovf_cnt;
    send(8'h34);
    check("t3_ovf_pulse", 32'(ovf_cnt), 32'(o0 + 1));
    check("t3_count_ovf", 32'(held_count), 32'd4);
    check("t3_newest_ovf", 32'(newest_code), 32'h02D);
    expect_evt(9'h01C, 1'b0, 1'b0);
    send(8'hF0); send(8'h1C);
    expect_evt(9'h035, 1'b1, 1'b0);
    send(8'h35);
    check("t3_reuse_slot1", 32'(slot(1)), 32'h035);
    check("t3_valid_reuse", 32'(held_valid), 32'hF);
    expect_evt(9'h015, 1'b0, 1'b0); send(8'hF0); send(8'h15);
    expect_evt(9'h024, 1'b0, 1'b0); send(8'hF0); send(8'h24);
    expect_evt(9'h02D, 1'b0, 1'b0); send(8'hF0); send(8'h2D);
    expect_evt(9'h035, 1'b0, 1'b0); send(8'hF0); send(8'h35);
    check("t3_empty", 32'(held_count), 32'd0);

    // Pause sequence produces nothing, next key works
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    check("t4_pause_count", 32'(held_count), 32'd0);
    expect_evt(9'h029, 1'b1, 1'b0);
    send(8'h29);
    check("t4_slot0", 32'(slot(0)), 32'h029);
    expect_evt(9'h029, 1'b0, 1'b0);
    send(8'hF0); send(8'h29);

    // Abandoned E0 prefix, fake shift, ignored status byte
    send(8'hE0);
    idle(3 * TU);
    expect_evt(9'h075, 1'b1, 1'b0);
    send(8'h75);
    check("t5_timeout_newest", 32'(newest_code), 32'h075);
    send(8'hE0); send(8'h12);
    send(8'hFA);
    check("t5_fake_count", 32'(held_count), 32'd1);
    expect_evt(9'h075, 1'b0, 1'b0);
    send(8'hF0); send(8'h75);

    // Typematic repeats then keyboard overrun flush
    expect_evt(9'h029, 1'b1, 1'b0);
    send(8'h29);
`ifdef KEY_TRACKER_REPEAT_EN
    expect_evt(9'h029, 1'b1, 1'b1);
    expect_evt(9'h029, 1'b1, 1'b1);
`endif
    send(8'h29); send(8'h29);
    check("t6_count_rep", 32'(held_count), 32'd1);
    o0 = ovf_cnt;
    send(8'hFF);
    check("t6_ovf_flush", 32'(ovf_cnt), 32'(o0 + 1));
    check("t6_count_flush", 32'(held_count), 32'd0);
    check("t6_newest_flush", 32'(newest_code), 32'h000);

    idle(4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_tracker.md
Name: ps2_key_tracker

Overview:
- Parametrised successor to the single-held-key latch.
- Consumes the byte stream from PS2_Controller (received_data / received_data_en) and decodes make, break, E0-extended and E1 (Pause) sequences.
- Maintains a table of up to MAX_KEYS simultaneously held keys, so game logic can test jump and duck together, e.g. while another key is held.
- Sits between PS2_Controller and the game FSM; the top level instantiates both.

Parameters:
- MAX_KEYS, 4, number of held-key slots (1..8).
- CLOCK_FREQUENCY, 25000000, Clock rate in Hz; used only to derive the timeout.
- TIMEOUT_US, 2000, microseconds without a byte before a partial sequence is abandoned.

Ports:
- Clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ps2_byte  in  8  received scan byte.
- ps2_byte_valid  in  1  one-cycle strobe qualifying ps2_byte.
- held_codes  out  9*MAX_KEYS  slot i in bits [9i+8:9i]; bit 8 = extended (E0) flag, bits 7:0 = scan code.
- held_valid  out  MAX_KEYS  slot-occupied flags.
- held_count  out  $clog2(MAX_KEYS+1)  number of occupied slots.
- newest_code  out  9  most recently pressed key still held; 0 if none.
- key_event  out  1  one-cycle pulse on each accepted press or release.
- event_code  out  9  code for key_event; holds its value between events.
- event_make  out  1  1 = press, 0 = release; valid with key_event.
- overflow  out  1  one-cycle pulse: press dropped because the table is full, or keyboard overrun byte received.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, all slots empty, FSM in IDLE, timeout counter 0.
- Registered outputs: table, event and overflow outputs update on the Clock edge after the ps2_byte_valid cycle carrying a sequence's final byte. Latency is 1 cycle.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP.
- IDLE transitions:
  - E0 -> EXT; F0 -> BRK.
  - E1 -> SKIP with skip counter = 7.
  - 00 or FF (keyboard overrun) -> flush all slots, newest_code = 0, overflow pulse, no key_event.
  - AA, FA, FE, EE -> ignored.
  - Any other byte -> make(code = {0, byte}).
- EXT: F0 -> EXT_BRK; 12 or 59 (fake shift) -> IDLE with no action; other -> make({1, byte}), IDLE.
- BRK: break({0, byte}), IDLE.
- EXT_BRK: 12 or 59 -> IDLE with no action; other -> break({1, byte}), IDLE.
- SKIP: decrement the skip counter on each byte; return to IDLE when it reaches 0. No table change (Pause is not tracked).
- make(c):
  - If c is already in the table (typematic repeat): no change, no key_event.
  - Else, if a free slot exists: write c to the lowest-index free slot, newest_code = c, key_event = 1, event_make = 1.
  - Else (table full): overflow pulse, table unchanged.
- break(c):
  - If c matches a slot: clear that slot, key_event = 1, event_make = 0, event_code = c. If c == newest_code, newest_code = 0.
  - Unmatched break: ignored silently.
- Slots never compact; a freed slot is reused by the next make.
- Timeout:
  - The counter clears on every ps2_byte_valid and increments while the FSM is not in IDLE.
  - At TIMEOUT_US*CLOCK_FREQUENCY/1e6 cycles the FSM returns to IDLE with no table change.
  - The counter saturates and does not run in IDLE.
- A strobe arriving on the same cycle the timeout fires: the byte is processed as if the FSM were in IDLE.
- held_count is combinational popcount of held_valid, registered with the table.

Optional Feature:
- Macro: KEY_TRACKER_REPEAT_EN.
- Defined: adds output key_repeat (1 bit). A make of an already-held code pulses key_event with event_make = 1, event_code = c and key_repeat = 1. Table unchanged.
- Undefined: port absent; repeats are silent as described above.

Decomposition:
- Package ps2_key_pkg:
  - FSM state enum.
  - Byte constants: PFX_EXT = E0, PFX_BRK = F0, PFX_PAUSE = E1, BAT_OK = AA, ACK = FA, RESEND = FE, ECHO = EE, KB_OVR0 = 00, KB_OVR1 = FF, FAKE_SHIFT_L = 12, FAKE_SHIFT_R = 59.
  - KEY_W = 9; KEY_NONE = 9'h000.
- Sub-module ps2_key_table: slot storage, parallel match, lowest-free-slot priority encoder, insert/remove/flush commands, popcount.

Test Plan:
- Bytes 29, then F0 29 -> key_event make 029, held_count 1; then key_event break 029, held_count 0, newest_code 000.
- Bytes 1D, E0 75, then F0 1D -> slot0 = 01D, slot1 = 175, newest_code 175; after the break, slot0 empty and newest_code stays 175.
- Five distinct makes with MAX_KEYS = 4 -> fourth make fills slot3; fifth pulses overflow, held_count stays 4; a later break of slot1's code then a new make -> new code lands in slot1.
- Pause sequence E1 14 77 E1 F0 14 F0 77, then 29 -> no event during Pause; 029 inserted afterwards.
- E0 alone, then idle past the timeout, then 75 -> make 075 (not 175); also E0 12 -> no event.
- 29 29 29 with repeat macro off -> exactly one key_event. With KEY_TRACKER_REPEAT_EN -> two extra pulses with key_repeat = 1. Then FF -> table flushed, overflow pulse.
